// File: rtl/expanda_sequencer.sv
// Sequencer for the ExpandA matrix. It launches one sampler job per (i, j) entry in
// row-major order and streams the accepted coefficients into the coefficient memory.
module expanda_sequencer #(
    parameter int K      = 4,
    parameter int L      = 4,
    parameter int ADDR_W = 13,
    parameter int COEF_W = 23
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start_expandA,
    input  logic [255:0]      rho,
    output logic              busy,
    output logic              done_expandA,
    output logic              err,
    output logic              smp_start,
    output logic [271:0]      smp_seed,
    input  logic              smp_coef_valid,
    input  logic [COEF_W-1:0] smp_coef,
    input  logic              smp_done,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [COEF_W-1:0] mem_wdata
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_COLLECT,
        S_NEXT,
        S_DONE
    } state_t;

    localparam logic [7:0] K_LAST = 8'(K - 1);
    localparam logic [7:0] L_LAST = 8'(L - 1);
    localparam logic [8:0] N_FULL = 9'd256;

    state_t       state_q, state_d;
    logic [7:0]   i_q, i_d;
    logic [7:0]   j_q, j_d;
    logic [8:0]   n_q, n_d;
    logic [255:0] rho_q, rho_d;
    logic         err_q, err_d;
    logic         busy_q, busy_d;
    logic         done_q, done_d;
    logic         start_q, start_d;

    logic              coef_wr;
    logic [8:0]        n_inc;
    logic [ADDR_W-1:0] entry_idx;

    always_comb begin
        state_d   = state_q;
        i_d       = i_q;
        j_d       = j_q;
        n_d       = n_q;
        rho_d     = rho_q;
        err_d     = err_q;
        coef_wr   = 1'b0;
        n_inc     = n_q;
        entry_idx = ADDR_W'(i_q) * ADDR_W'(L) + ADDR_W'(j_q);

        case (state_q)
            S_IDLE: begin
                if (start_expandA) begin
                    rho_d   = rho;
                    i_d     = '0;
                    j_d     = '0;
                    n_d     = '0;
                    err_d   = 1'b0;
                    state_d = S_ISSUE;
                end
            end
            S_ISSUE: state_d = S_COLLECT;
            S_COLLECT: begin
                // The write is accounted for first so a simultaneous done sees the new count.
                if (smp_coef_valid) begin
                    if (n_q == N_FULL) begin
                        err_d = 1'b1;
                    end else begin
                        coef_wr = 1'b1;
                        n_inc   = n_q + 9'd1;
                    end
                end
                n_d = n_inc;
                if (smp_done) begin
                    if (n_inc != N_FULL) err_d = 1'b1;
                    state_d = S_NEXT;
                end
            end
            S_NEXT: begin
                n_d = '0;
                if (j_q == L_LAST) begin
                    j_d = '0;
                    i_d = i_q + 8'd1;
                end else begin
                    j_d = j_q + 8'd1;
                end
                state_d = (i_q == K_LAST && j_q == L_LAST) ? S_DONE : S_ISSUE;
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        busy_d  = (state_d != S_IDLE);
        done_d  = (state_d == S_DONE);
        start_d = (state_d == S_ISSUE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            i_q     <= '0;
            j_q     <= '0;
            n_q     <= '0;
            rho_q   <= '0;
            err_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            start_q <= 1'b0;
        end else begin
            state_q <= state_d;
            i_q     <= i_d;
            j_q     <= j_d;
            n_q     <= n_d;
            rho_q   <= rho_d;
            err_q   <= err_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            start_q <= start_d;
        end
    end

    // Memory port is gated by the write strobe so it idles at zero between writes.
    assign mem_we       = coef_wr;
    assign mem_addr     = coef_wr ? (entry_idx << 8) + ADDR_W'(n_q) : '0;
    assign mem_wdata    = coef_wr ? smp_coef : '0;
    assign smp_seed     = {i_q, j_q, rho_q};
    assign smp_start    = start_q;
    assign busy         = busy_q;
    assign done_expandA = done_q;
    assign err          = err_q;

endmodule

// File: doc/expanda_sequencer.md
Name: expanda_sequencer

Overview:
- Top-level controller that sequences generation of the public matrix A (K rows x L columns of 256-coefficient polynomials) from seed rho.
- Issues one rejection-sampler job per matrix entry in row-major order and builds each 272-bit seed as rho || column byte || row byte.
- Streams the accepted coefficients into the coefficient memory at linear addresses.
- Sits between the key-generation/sign control FSM and the SHAKE128 sampler plus coefficient RAM.

Parameters:
- K, 4, number of matrix rows (4/6/8 for ML-DSA-44/65/87).
- L, 4, number of matrix columns (4/5/7).
- ADDR_W, 13, coefficient memory address width; must satisfy 2^ADDR_W >= K*L*256.
- COEF_W, 23, coefficient width (q = 8380417).

Ports:
- clk  in  1  system clock, all logic on rising edge
- rst  in  1  synchronous active-high reset
- start_expandA  in  1  one-cycle request to build A
- rho  in  256  matrix seed, sampled only in the cycle start_expandA is accepted
- busy  out  1  high from accept until the done cycle, inclusive
- done_expandA  out  1  one-cycle pulse when all K*L polynomials are written
- err  out  1  sticky sampler protocol error, cleared on the next accepted start
- smp_start  out  1  one-cycle job launch to the sampler
- smp_seed  out  272  [255:0]=rho, [263:256]=column j, [271:264]=row i; held stable while a job is active
- smp_coef_valid  in  1  sampler presents one accepted coefficient
- smp_coef  in  COEF_W  coefficient value
- smp_done  in  1  sampler job finished
- mem_we  out  1  coefficient write strobe
- mem_addr  out  ADDR_W  ((i*L + j) << 8) + n
- mem_wdata  out  COEF_W  coefficient to write

Behaviour:
- Reset: state=IDLE, i=j=n=0, rho_q=0. All outputs are 0 (busy, done_expandA, err, smp_start, smp_seed, mem_we, mem_addr, mem_wdata). Reset applies mid-operation: the job is abandoned, no further writes occur, and sampler strobes are ignored until the next accepted start.
- IDLE:
  - start_expandA=1 latches rho into rho_q and sets i=0, j=0, n=0.
  - It also clears err, sets busy=1 and goes to ISSUE.
- ISSUE:
  - Asserts smp_start for exactly one cycle, with smp_seed built from rho_q, i and j.
  - Goes to COLLECT next cycle.
- COLLECT, on each smp_coef_valid with n<256:
  - Same cycle, combinationally: mem_we=1, mem_addr=((i*L+j)<<8)+n, mem_wdata=smp_coef.
  - Then n increments.
  - Write latency from valid to memory strobe: 0 cycles.
- COLLECT, on smp_coef_valid with n==256: no write, and err is set.
- COLLECT, on smp_done:
  - If n!=256, err is set; missing coefficients stay unwritten and the sequence continues.
  - Goes to NEXT.
  - If smp_done and smp_coef_valid arrive in the same cycle, the coefficient is written first and then the done check uses the updated count.
- NEXT (1 cycle):
  - n=0; j increments.
  - When j==L-1, j wraps to 0 and i increments.
  - When i==K-1 and j==L-1, go to DONE; otherwise go to ISSUE.
- DONE (1 cycle): done_expandA=1 and busy=1, then IDLE with busy=0.
- start_expandA while busy=1 is ignored; rho_q does not change.
- start_expandA in the DONE cycle is ignored. A start is first accepted in the following IDLE cycle.
- Sampler strobes outside COLLECT are ignored and do not set err.
- Overall latency is 2 + sum(sampler cycles) + K*L*3 cycles (ISSUE, NEXT and smp_done handling per entry).
- Address arithmetic is unsigned. There is no memory back-pressure; the memory must accept one write per cycle.

Test Plan:
- Single run, K=L=4, rho=0f2ebf0e...deda1f1c, sampler model emitting 256 coefficients per job:
  - 16 smp_start pulses with seed bytes (j,i) = (0,0),(1,0),...,(3,3).
  - 4096 writes at addresses 0..4095 in order.
  - done_expandA pulses once; err=0; memory matches the golden ExpandA file.
- Address mapping check: job i=2, j=1 -> first write to address 2304 (0x900), last to 2559.
- Short job: the sampler raises smp_done after 200 coefficients on entry (1,3) -> err=1 stays set, and the next job starts at address 2048.
- Over-run: a 257th coefficient arrives before smp_done -> no write at address 256 of the next entry, and err=1.
- A second start_expandA with a different rho mid-run -> ignored, and all seeds keep the original rho. A start in the cycle after done is accepted and clears err.
- Reset asserted during entry (2,0) -> all outputs 0 next cycle, then a fresh start restarts at i=0, j=0, address 0.
